// File: rtl/lc3_io_pkg.sv
// Shared constants and address decode for the LC-3 memory-mapped I/O responder.
package lc3_io_pkg;

  localparam logic [15:0] KBSR_OFF = 16'h0000;
  localparam logic [15:0] KBDR_OFF = 16'h0002;
  localparam logic [15:0] DSR_OFF  = 16'h0004;
  localparam logic [15:0] DDR_OFF  = 16'h0006;

  localparam int READY_BIT = 15;
  localparam int IE_BIT    = 14;

  localparam logic [15:0] DSR_RST = 16'h8000;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_KBSR = 3'd1,
    SEL_KBDR = 3'd2,
    SEL_DSR  = 3'd3,
    SEL_DDR  = 3'd4
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [15:0] ma, input logic [15:0] base);
    reg_sel_e sel;
    if (ma == base + KBSR_OFF) begin
      sel = SEL_KBSR;
    end else if (ma == base + KBDR_OFF) begin
      sel = SEL_KBDR;
    end else if (ma == base + DSR_OFF) begin
      sel = SEL_DSR;
    end else if (ma == base + DDR_OFF) begin
      sel = SEL_DDR;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/lc3_io_responder_if.sv
// CPU strobes/address plus keyboard and display handshakes of the I/O responder.
// MD stays a plain inout port on the responder because it is a shared tri-state bus.
interface lc3_io_responder_if;
  logic [15:0] MA;
  logic        rd;
  logic        we;
  logic        io_sel;
  logic        irq;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output MA, rd, we, rx_data, rx_valid, tx_ready,
    input  io_sel, irq, rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  MA, rd, we, rx_data, rx_valid, tx_ready,
    output io_sel, irq, rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/lc3_io_responder_rx_fifo.sv
// Keyboard receive FIFO: byte-wide, power-of-two depth, push/pop in the same cycle allowed.
module io_rx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign full      = (count_q == CNT_MAX);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO and blocks any push.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage needs no reset; reads are gated by the occupancy count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/lc3_io_responder.sv
// LC-3 memory-mapped I/O responder: KBSR/KBDR/DSR/DDR decode, keyboard FIFO,
// display byte register and active-low interrupt request.
module lc3_io_responder
  import lc3_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFE00,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  lc3_io_responder_if.slave   bus,
  inout  wire  [15:0]         MD
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  reg_sel_e      sel_s;
  logic          hit_s, rd_drv_s, wr_s, kbdr_rd_s, pop_s;
  logic [15:0]   md_in_s, rdata_s;
  logic          unused_md_s;
  logic [7:0]    head_s;
  logic          full_s, empty_s;
  logic [CW-1:0] count_s;

  logic       kie_q, kie_d;
  logic       die_q, die_d;
  logic       dsr_ready_q, dsr_ready_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic       irq_q, irq_d;
  logic       kbdr_rd_q, kbdr_rd_d;
  logic [7:0] kbdr_last_q, kbdr_last_d;

  assign sel_s       = decode_addr(bus.MA, BASE_ADDR);
  assign hit_s       = (sel_s != SEL_NONE);
  assign wr_s        = hit_s & bus.we;
  // A simultaneous write strobe suppresses both the bus drive and the pop.
  assign rd_drv_s    = hit_s & bus.rd & ~bus.we;
  assign kbdr_rd_s   = (sel_s == SEL_KBDR) & bus.rd & ~bus.we;
  assign pop_s       = kbdr_rd_s & ~kbdr_rd_q;
  assign md_in_s     = MD;
  assign unused_md_s = ^{md_in_s[15], md_in_s[13:8]};

  io_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.rx_valid),
    .din   (bus.rx_data),
    .pop   (pop_s),
    .head  (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Read data mux for the selected device register.
  always_comb begin
    rdata_s = 16'h0000;
    case (sel_s)
      SEL_KBSR: begin
        rdata_s[READY_BIT] = ~empty_s;
        rdata_s[IE_BIT]    = kie_q;
      end
      SEL_KBDR: rdata_s = {8'h00, (empty_s ? kbdr_last_q : head_s)};
      SEL_DSR: begin
        rdata_s[READY_BIT] = dsr_ready_q;
        rdata_s[IE_BIT]    = die_q;
      end
      SEL_DDR:  rdata_s = {8'h00, tx_data_q};
      default:  rdata_s = 16'h0000;
    endcase
  end

  assign MD           = rd_drv_s ? rdata_s : 16'hzzzz;
  assign bus.io_sel   = hit_s & (bus.rd | bus.we);
  assign bus.irq      = irq_q;
  assign bus.rx_ready = ~full_s;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;

  // Register writes, display handshake, pop tracking and interrupt next-state.
  always_comb begin
    kie_d       = kie_q;
    die_d       = die_q;
    dsr_ready_d = dsr_ready_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    kbdr_rd_d   = kbdr_rd_s;
    kbdr_last_d = kbdr_last_q;
    if (wr_s) begin
      case (sel_s)
        SEL_KBSR: kie_d = md_in_s[IE_BIT];
        SEL_DSR:  die_d = md_in_s[IE_BIT];
        SEL_DDR: begin
          if (dsr_ready_q) begin
            tx_data_d   = md_in_s[7:0];
            tx_valid_d  = 1'b1;
            dsr_ready_d = 1'b0;
          end else begin
            tx_valid_d  = tx_valid_q;
          end
        end
        default: kie_d = kie_q;
      endcase
    end else begin
      kie_d = kie_q;
    end
    if (tx_valid_q && bus.tx_ready) begin
      tx_valid_d  = 1'b0;
      dsr_ready_d = 1'b1;
    end else begin
      dsr_ready_d = dsr_ready_d;
    end
    if (pop_s && (count_s != '0)) begin
      kbdr_last_d = head_s;
    end else begin
      kbdr_last_d = kbdr_last_q;
    end
    irq_d = ~((~empty_s & kie_q) | (dsr_ready_q & die_q));
  end

  // State registers; reset overrides any concurrent transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      kie_q       <= DSR_RST[IE_BIT];
      die_q       <= DSR_RST[IE_BIT];
      dsr_ready_q <= DSR_RST[READY_BIT];
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      irq_q       <= 1'b1;
      kbdr_rd_q   <= 1'b0;
      kbdr_last_q <= 8'h00;
    end else begin
      kie_q       <= kie_d;
      die_q       <= die_d;
      dsr_ready_q <= dsr_ready_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      irq_q       <= irq_d;
      kbdr_rd_q   <= kbdr_rd_d;
      kbdr_last_q <= kbdr_last_d;
    end
  end
endmodule

// File: tb/tb_lc3_io_responder.sv
// Directed vector bench for lc3_io_responder: one table row per clock cycle,
// followed by hand-written reset-during-transfer and display handshake sequences.
module tb_lc3_io_responder;
  typedef struct {
    string       nm;
    logic [15:0] ma;
    logic        rd, we, md_en;
    logic [15:0] md;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic        chk;
    logic [15:0] emd;
    logic        eio, eirq, erxr, etxv;
    logic [7:0]  etxd;
  } vec_t;

  localparam logic [15:0] K  = 16'hFE00;
  localparam logic [15:0] KD = 16'hFE02;
  localparam logic [15:0] D  = 16'hFE04;
  localparam logic [15:0] DD = 16'hFE06;
  localparam logic [15:0] NA = 16'h0000;
  localparam logic [15:0] KP = 16'h0A0A;

  logic        clk;
  logic        reset;
  logic        md_en;
  logic [15:0] md_val;
  wire  [15:0] MD;
  logic [15:0] md_s;
  int          n_vec;
  int          n_miss;
  vec_t        vecs[$];

  lc3_io_responder_if bus();

  assign MD   = md_en ? md_val : 16'hzzzz;
  assign md_s = MD;

  lc3_io_responder #(.BASE_ADDR(16'hFE00), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .MD    (MD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  task automatic add(input string nm, input logic [15:0] ma, input logic rd, input logic we,
                     input logic mden, input logic [15:0] md, input logic rxv, input logic [7:0] rxd,
                     input logic txr, input logic chk, input logic [15:0] emd, input logic eio,
                     input logic eirq, input logic erxr, input logic etxv, input logic [7:0] etxd);
    vec_t v;
    v.nm = nm; v.ma = ma; v.rd = rd; v.we = we; v.md_en = mden; v.md = md;
    v.rxv = rxv; v.rxd = rxd; v.txr = txr; v.chk = chk; v.emd = emd;
    v.eio = eio; v.eirq = eirq; v.erxr = erxr; v.etxv = etxv; v.etxd = etxd;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [15:0] ma, input logic rd, input logic we, input logic mden,
                       input logic [15:0] md, input logic rxv, input logic [7:0] rxd, input logic txr);
    bus.MA = ma; bus.rd = rd; bus.we = we; md_en = mden; md_val = md;
    bus.rx_valid = rxv; bus.rx_data = rxd; bus.tx_ready = txr;
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  initial begin
    bool_t_dummy: begin end
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b0;
    drive(NA, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);

    //  name            MA  rd    we    mden  MD        rxv   rxd    txr   chk   expMD     io    irq   rxr   txv   txd
    add("rst_dsr",      D,  1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    add("rst_kbsr",     K,  1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    add("rst_kbdr",     KD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    add("idle",         NA, 1'b0, 1'b0, 1'b1, KP,       1'b0, 8'h00, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add("push41_kie",   K,  1'b0, 1'b1, 1'b1, 16'h4000, 1'b1, 8'h41, 1'b0, 1'b1, 16'h4000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    add("push42",       NA, 1'b0, 1'b0, 1'b1, KP,       1'b1, 8'h42, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add("rd_kbdr_41",   KD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0041, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    add("gap_a",        NA, 1'b0, 1'b0, 1'b1, KP,       1'b0, 8'h00, 1'b0, 1'b1, KP,       1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    add("rd_kbdr_42",   KD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0042, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    add("kbsr_empty",   K,  1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h4000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    add("kbdr_last",    KD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0042, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    add("push31",       NA, 1'b0, 1'b0, 1'b1, KP,       1'b1, 8'h31, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add("push32",       NA, 1'b0, 1'b0, 1'b1, KP,       1'b1, 8'h32, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add("hold_rd_1",    KD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0031, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    add("hold_rd_2",    KD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0032, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    add("hold_rd_3",    KD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0032, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    add("kbsr_held",    K,  1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'hC000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    add("rd_kbdr_32",   KD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0032, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    add("kie_off",      K,  1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    add("irq_clear",    NA, 1'b0, 1'b0, 1'b1, KP,       1'b0, 8'h00, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add("push51",       NA, 1'b0, 1'b0, 1'b1, KP,       1'b1, 8'h51, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add("push52",       NA, 1'b0, 1'b0, 1'b1, KP,       1'b1, 8'h52, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add("push53",       NA, 1'b0, 1'b0, 1'b1, KP,       1'b1, 8'h53, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add("push54",       NA, 1'b0, 1'b0, 1'b1, KP,       1'b1, 8'h54, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add("push55_full",  NA, 1'b0, 1'b0, 1'b1, KP,       1'b1, 8'h55, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    add("rd_kbdr_51",   KD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0051, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    add("rx_free",      NA, 1'b0, 1'b0, 1'b1, KP,       1'b0, 8'h00, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add("rd_kbdr_52",   KD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0052, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    add("gap_b",        NA, 1'b0, 1'b0, 1'b1, KP,       1'b0, 8'h00, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add("rd_kbdr_53",   KD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0053, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    add("gap_c",        NA, 1'b0, 1'b0, 1'b1, KP,       1'b0, 8'h00, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add("rd_kbdr_54",   KD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0054, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    add("gap_d",        NA, 1'b0, 1'b0, 1'b1, KP,       1'b0, 8'h00, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    add("kbsr_drained", K,  1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    add("ddr_wr58",     DD, 1'b0, 1'b1, 1'b1, 16'h0058, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0058, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    add("dsr_busy",     D,  1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 8'h58);
    add("ddr_drop59",   DD, 1'b0, 1'b1, 1'b1, 16'h0059, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0059, 1'b1, 1'b1, 1'b1, 1'b1, 8'h58);
    add("ddr_rd58",     DD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0058, 1'b1, 1'b1, 1'b1, 1'b1, 8'h58);
    add("die_on",       D,  1'b0, 1'b1, 1'b1, 16'h4000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h4000, 1'b1, 1'b1, 1'b1, 1'b1, 8'h58);
    add("tx_handshake", NA, 1'b0, 1'b0, 1'b1, KP,       1'b0, 8'h00, 1'b1, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b1, 8'h58);
    add("dsr_ready",    D,  1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'hC000, 1'b1, 1'b1, 1'b1, 1'b0, 8'h58);
    add("irq_die",      NA, 1'b0, 1'b0, 1'b1, KP,       1'b0, 8'h00, 1'b0, 1'b1, KP,       1'b0, 1'b0, 1'b1, 1'b0, 8'h58);
    add("ddr_wr61",     DD, 1'b0, 1'b1, 1'b1, 16'h0061, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0061, 1'b1, 1'b0, 1'b1, 1'b0, 8'h58);
    add("ddr_wr62_hs",  DD, 1'b0, 1'b1, 1'b1, 16'h0062, 1'b0, 8'h00, 1'b1, 1'b1, 16'h0062, 1'b1, 1'b0, 1'b1, 1'b1, 8'h61);
    add("ddr_rd61",     DD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0061, 1'b1, 1'b1, 1'b1, 1'b0, 8'h61);
    add("rdwe_ddr33",   DD, 1'b1, 1'b1, 1'b1, 16'h0033, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0033, 1'b1, 1'b0, 1'b1, 1'b0, 8'h61);
    add("tx33_latched", NA, 1'b0, 1'b0, 1'b1, KP,       1'b0, 8'h00, 1'b0, 1'b1, KP,       1'b0, 1'b0, 1'b1, 1'b1, 8'h33);
    add("na_rd_fe08",   16'hFE08, 1'b1, 1'b0, 1'b1, KP, 1'b0, 8'h00, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b1, 8'h33);
    add("na_wr_fe08",   16'hFE08, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 8'h00, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33);
    add("dsr_after_na", D,  1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h4000, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
    add("push71",       NA, 1'b0, 1'b0, 1'b1, KP,       1'b1, 8'h71, 1'b0, 1'b1, KP,       1'b0, 1'b1, 1'b1, 1'b1, 8'h33);
    add("rdwe_kbdr",    KD, 1'b1, 1'b1, 1'b1, KP,       1'b0, 8'h00, 1'b0, 1'b1, KP,       1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
    add("kbsr_71",      K,  1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
    add("rd_kbdr_71",   KD, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0071, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
    add("kbsr_final",   K,  1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33);

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].ma, vecs[i].rd, vecs[i].we, vecs[i].md_en, vecs[i].md,
            vecs[i].rxv, vecs[i].rxd, vecs[i].txr);
      #1;
      n_vec++;
      if ((vecs[i].chk && (md_s !== vecs[i].emd)) || (bus.io_sel !== vecs[i].eio) ||
          (bus.irq !== vecs[i].eirq) || (bus.rx_ready !== vecs[i].erxr) ||
          (bus.tx_valid !== vecs[i].etxv) || (bus.tx_data !== vecs[i].etxd)) begin
        n_miss++;
        $display("FAIL %s: got md=%h io_sel=%b irq=%b rx_ready=%b tx_valid=%b tx_data=%h, required md=%h io_sel=%b irq=%b rx_ready=%b tx_valid=%b tx_data=%h",
                 vecs[i].nm, md_s, bus.io_sel, bus.irq, bus.rx_ready, bus.tx_valid, bus.tx_data,
                 vecs[i].emd, vecs[i].eio, vecs[i].eirq, vecs[i].erxr, vecs[i].etxv, vecs[i].etxd);
      end
    end

    // Reset while a tx byte is pending and an rx byte is offered.
    @(negedge clk);
    drive(NA, 1'b0, 1'b0, 1'b1, KP, 1'b1, 8'h99, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    drive(NA, 1'b0, 1'b0, 1'b1, KP, 1'b0, 8'h00, 1'b0);
    #1;
    check("rst_mid_tx_valid", {15'h0000, bus.tx_valid}, 16'h0000);
    check("rst_mid_tx_data", {8'h00, bus.tx_data}, 16'h0000);
    check("rst_mid_irq", {15'h0000, bus.irq}, 16'h0001);
    check("rst_mid_rx_ready", {15'h0000, bus.rx_ready}, 16'h0001);
    @(negedge clk);
    drive(K, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    #1 check("rst_mid_kbsr", md_s, 16'h0000);
    @(negedge clk);
    drive(D, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    #1 check("rst_mid_dsr", md_s, 16'h8000);

    // Display write, then a bounded wait for the sink handshake to retire it.
    @(negedge clk);
    drive(DD, 1'b0, 1'b1, 1'b1, 16'h0077, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    drive(NA, 1'b0, 1'b0, 1'b1, KP, 1'b0, 8'h00, 1'b1);
    #1 check("tx77_data", {8'h00, bus.tx_data}, 16'h0077);
    begin
      int waited;
      waited = 0;
      while (bus.tx_valid === 1'b1 && waited < 8) begin
        @(negedge clk);
        #1 waited++;
      end
      check("tx77_retired", {15'h0000, bus.tx_valid}, 16'h0000);
    end
    drive(D, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    #1 check("tx77_dsr_ready", md_s, 16'h8000);

    @(negedge clk);
    drive(NA, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/lc3_io_responder.md
# lc3_io_responder

Memory-mapped I/O responder on the LC-3 processor's external data bus (MA, MD, rd, we). It answers CPU accesses to the four standard device registers KBSR/KBDR/DSR/DDR, buffers incoming keyboard bytes in a small FIFO, and hands display bytes to a downstream sink. It also drives the active-low irq input that the CPU's interrupt logic samples on the falling edge. It sits beside the data memory at the top level; io_sel tells the top level to steer MD away from memory.

## Interface
- BASE_ADDR, 16'hFE00: address of KBSR; KBDR = +2, DSR = +4, DDR = +6.
- FIFO_DEPTH, 4: keyboard receive FIFO entries; power of two, ≥2.
- clk  in  1  system clock, rising edge; same clock as the CPU core.
- reset  in  1  reset, **synchronous, active-low**: sampled on the rising clk edge, 0 = reset.
- MA  in  16  CPU address bus.
- MD  inout  16  CPU data bus; this block drives it only during a decoded read.
- rd  in  1  CPU read strobe, active-high.
- we  in  1  CPU write strobe, active-high.
- io_sel  out  1  combinational; 1 when MA matches one of the four registers and rd or we is high.
- irq  out  1  registered interrupt request to the CPU, active-low.
- rx_data  in  8  keyboard byte.
- rx_valid  in  1  keyboard byte present.
- rx_ready  out  1  FIFO can accept a byte; a transfer occurs when rx_valid & rx_ready at the rising edge.
- tx_data  out  8  display byte.
- tx_valid  out  1  display byte pending.
- tx_ready  in  1  sink accepts; a transfer occurs when tx_valid & tx_ready at the rising edge.

## Operation
- **Register map.** Reads return 16-bit values, with unlisted bits read as 0.
  - KBSR: bit 15 = FIFO non-empty, bit 14 = KIE (read/write).
  - KBDR: {8'h00, FIFO head}. When the FIFO is empty, it returns the last popped byte (or 0 after reset).
  - DSR: bit 15 = display ready, bit 14 = DIE (read/write).
  - DDR: reads {8'h00, last written byte}.
- **Read.** When rd=1, we=0 and the address matches, MD is driven combinationally with the selected register. In every other case MD is 16'hzzzz.
- **KBDR pop.** The FIFO pops once per read access, on the first rising edge of a contiguous run of cycles with rd=1 and MA=KBDR. This is detected with a registered copy of that hit condition. A stalled CPU holding rd high must not drain extra bytes. A pop on an empty FIFO has no effect.
- **Write.** On a rising edge with we=1 and an address match:
  - KBSR[14] and DSR[14] are the only writable status bits; other status bits ignore writes.
  - A write to KBDR is ignored.
  - DDR write when DSR[15]=1: latch MD[7:0] into tx_data, set tx_valid=1, clear DSR[15].
  - DDR write when DSR[15]=0 (busy): dropped, with no state change.
- **Both strobes high.** If rd and we are both high, we wins: the write is performed, MD is not driven, and no pop occurs.
- **Receive FIFO.**
  - rx_ready = !full.
  - A push and a pop in the same cycle are both performed, and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.
- **Display handshake.** When tx_valid & tx_ready: clear tx_valid and set DSR[15]. A DDR write in that same cycle is dropped, because DSR[15] was still 0 when it was sampled.
- **Interrupt.** The next value of irq = !((KBSR[15] & KBSR[14]) | (DSR[15] & DSR[14])), registered.
- **Reset values.** MD = z, io_sel = 0 (combinational), irq = 1, rx_ready = 1, tx_valid = 0, tx_data = 0, KBSR = 0, FIFO empty, KBDR = 0, DSR = 16'h8000, KIE = DIE = 0.
- **Reset during a transfer.** Reset wins over every concurrent event: a pending tx byte is discarded, and a simultaneous rx push is not accepted.

## Timing
- **Read data.** Zero-cycle latency: MD is valid in the same cycle as MA/rd, before the CPU's capturing edge.
- **Status after receive.** An rx push at edge N makes KBSR[15]=1 readable from cycle N+1. irq falls at edge N+1 if KIE=1, i.e. visible from N+2.
- **Status after display write.** A DDR write at edge N gives tx_valid=1 and DSR[15]=0 from N+1. A tx handshake at edge M gives tx_valid=0 and DSR[15]=1 from M+1.
- **Interrupt clear.** Writing KIE=0 at edge N returns irq to 1 at edge N+1, provided DSR does not hold irq low.
- **Throughput.** One rx push and one register access per cycle are supported.

## Structure
- Package lc3_io_pkg holds:
  - the register offsets (KBSR_OFF=0, KBDR_OFF=2, DSR_OFF=4, DDR_OFF=6);
  - the bit positions READY_BIT=15 and IE_BIT=14;
  - the reset constant DSR_RST=16'h8000.
- Sub-module io_rx_fifo holds the synchronous FIFO: push, pop, head, full, empty and count, with parameter DEPTH. The top level contains address decode, the pop edge detect, the MD tri-state, the tx register and irq.

## Test plan
- **Reset.** Hold reset=0 for 2 cycles, then read DSR → 16'h8000; read KBSR → 16'h0000; irq=1; MD=z when idle.
- **Receive and read.** Push 8'h41 and 8'h42. Write KBSR=16'h4000 → irq=0 from 2 cycles after the first push. Read KBDR → 16'h0041. Read KBDR again → 16'h0042, then KBSR[15]=0 and irq=1 the following cycle.
- **Held read strobe.** Push 8'h31 and 8'h32. Hold rd=1 at KBDR for 3 cycles → exactly one pop, and KBSR[15] stays 1.
- **FIFO full.** Push 4 bytes with no reads → rx_ready=0. A fifth rx_valid is not accepted. One KBDR read → rx_ready=1 next cycle.
- **Display.** Write DDR=16'h0058 with tx_ready=0 → tx_data=8'h58, tx_valid=1, DSR=0. A second DDR write of 16'h0059 is dropped. Raise tx_ready for 1 cycle → tx_valid=0, DSR=16'h8000. With DIE=1, irq=0 one cycle later.
- **Strobe and bus conflicts.** rd=we=1 at DDR with MD=16'h0033 → write taken, MD not driven by the block. An access to 16'hFE08 → io_sel=0, no state change.
